// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the clock mode controller: the mode encoding
// driven on the mode output and the auto-repeat defaults.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2,
        MODE_BAD     = 2'd3
    } mode_e;

    // Ticks btn_inc must be held before auto-repeat starts
    localparam int REPEAT_DELAY_DEF = 2;

    // Width of the auto-repeat tick counter (REPEAT_DELAY up to 15)
    localparam int RPT_CNT_W = 4;

endpackage

// File: rtl/clock_mode_ctrl_rise_detect.sv
// rise_detect: one-cycle rising-edge flag for a debounced, clk1-synchronous
// button level. The edge is suppressed on the first clock after reset so a
// button held through reset does not register as a press.
module rise_detect (
    input  logic clk1,
    input  logic clr,
    input  logic lvl_i,
    output logic rise_o
);

    logic prev_q;
    logic armed_q;

    // Capture the previous level; arm once the first post-reset level is known
    always_ff @(posedge clk1 or posedge clr) begin
        if (clr) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= lvl_i;
            armed_q <= 1'b1;
        end
    end

    assign rise_o = lvl_i & ~prev_q & armed_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: run/set mode controller for a clock display.
// RUN counts seconds on tick with carries into minutes and hours; SET_HR and
// SET_MIN step the selected field on btn_inc presses and flash via blink.
// All outputs are registered: a qualifying input in cycle N shows in N+1.
// Optional feature macro: CLOCK_AUTOREPEAT_EN (holding btn_inc in a set
// mode repeats the increment once per tick after REPEAT_DELAY ticks).
module clock_mode_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF
) (
    input  logic       clk1,
    input  logic       clr,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_max,
    input  logic       min_max,
    output logic       inc_sec,
    output logic       inc_min,
    output logic       inc_hr,
    output logic       clr_sec,
    output logic [1:0] mode,
    output logic       blink
);

    if (REPEAT_DELAY < 1 || REPEAT_DELAY > (2 ** RPT_CNT_W) - 1) begin : g_bad_repeat_delay
        $error("REPEAT_DELAY must be in 1..15");
    end

    mode_e state_q, state_d;
    logic  blink_q, blink_d;
    logic  inc_sec_q, inc_sec_d;
    logic  inc_min_q, inc_min_d;
    logic  inc_hr_q, inc_hr_d;
    logic  clr_sec_q, clr_sec_d;
    logic  mode_rise;
    logic  inc_rise;
    logic  rpt_fire;

    rise_detect u_mode_rise (
        .clk1   (clk1),
        .clr    (clr),
        .lvl_i  (btn_mode),
        .rise_o (mode_rise)
    );

    rise_detect u_inc_rise (
        .clk1   (clk1),
        .clr    (clr),
        .lvl_i  (btn_inc),
        .rise_o (inc_rise)
    );

`ifdef CLOCK_AUTOREPEAT_EN
    localparam logic [RPT_CNT_W-1:0] RPT_LIM = RPT_CNT_W'(REPEAT_DELAY);

    logic [RPT_CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic                 in_set;

    assign in_set = (state_q == MODE_SET_HR) || (state_q == MODE_SET_MIN);

    // Count ticks while btn_inc stays held after its press; fire once per tick past the delay
    always_comb begin
        rpt_cnt_d = rpt_cnt_q;
        rpt_fire  = 1'b0;
        if (!btn_inc || !in_set || mode_rise || inc_rise) begin
            rpt_cnt_d = '0;
        end else if (tick) begin
            if (rpt_cnt_q == RPT_LIM) begin
                rpt_fire = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end
    end

    // Repeat counter register
    always_ff @(posedge clk1 or posedge clr) begin
        if (clr) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Next mode, blink and output pulses; a mode press always beats an inc press
    always_comb begin
        state_d   = state_q;
        blink_d   = blink_q;
        inc_sec_d = 1'b0;
        inc_min_d = 1'b0;
        inc_hr_d  = 1'b0;
        clr_sec_d = 1'b0;
        case (state_q)
            MODE_RUN: begin
                blink_d = 1'b0;
                if (tick) begin
                    inc_sec_d = 1'b1;
                    inc_min_d = sec_max;
                    inc_hr_d  = sec_max & min_max;
                end
                if (mode_rise) begin
                    state_d = MODE_SET_HR;
                    blink_d = 1'b1;
                end
            end
            MODE_SET_HR: begin
                if (mode_rise) begin
                    state_d = MODE_SET_MIN;
                    blink_d = 1'b1;
                end else begin
                    if (tick) blink_d = ~blink_q;
                    inc_hr_d = inc_rise | rpt_fire;
                end
            end
            MODE_SET_MIN: begin
                if (mode_rise) begin
                    state_d   = MODE_RUN;
                    blink_d   = 1'b0;
                    clr_sec_d = 1'b1;
                end else begin
                    if (tick) blink_d = ~blink_q;
                    inc_min_d = inc_rise | rpt_fire;
                end
            end
            default: begin
                state_d = MODE_RUN;
                blink_d = 1'b0;
            end
        endcase
    end

    // State, blink and pulse output registers
    always_ff @(posedge clk1 or posedge clr) begin
        if (clr) begin
            state_q   <= MODE_RUN;
            blink_q   <= 1'b0;
            inc_sec_q <= 1'b0;
            inc_min_q <= 1'b0;
            inc_hr_q  <= 1'b0;
            clr_sec_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            blink_q   <= blink_d;
            inc_sec_q <= inc_sec_d;
            inc_min_q <= inc_min_d;
            inc_hr_q  <= inc_hr_d;
            clr_sec_q <= clr_sec_d;
        end
    end

    assign mode    = state_q;
    assign blink   = blink_q;
    assign inc_sec = inc_sec_q;
    assign inc_min = inc_min_q;
    assign inc_hr  = inc_hr_q;
    assign clr_sec = clr_sec_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl. Observed vector per step is
// {mode[1:0], blink, clr_sec, inc_hr, inc_min, inc_sec}.
module tb_clock_mode_ctrl;

    logic       clk1 = 1'b0;
    logic       clr;
    logic       tick;
    logic       btn_mode;
    logic       btn_inc;
    logic       sec_max;
    logic       min_max;
    logic       inc_sec;
    logic       inc_min;
    logic       inc_hr;
    logic       clr_sec;
    logic [1:0] mode;
    logic       blink;

    int   errors = 0;
    int   checks = 0;
    logic exp_blink;
    logic rpt_on;

    always #5 clk1 = ~clk1;

    clock_mode_ctrl #(.REPEAT_DELAY(2)) dut (
        .clk1     (clk1),
        .clr      (clr),
        .tick     (tick),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec_max  (sec_max),
        .min_max  (min_max),
        .inc_sec  (inc_sec),
        .inc_min  (inc_min),
        .inc_hr   (inc_hr),
        .clr_sec  (clr_sec),
        .mode     (mode),
        .blink    (blink)
    );

    task automatic cyc();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] expv);
        logic [6:0] obs;
        obs = {mode, blink, clr_sec, inc_hr, inc_min, inc_sec};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    initial begin
`ifdef CLOCK_AUTOREPEAT_EN
        rpt_on = 1'b1;
`else
        rpt_on = 1'b0;
`endif
        clr = 1'b1; tick = 1'b0; btn_mode = 1'b1; btn_inc = 1'b0;
        sec_max = 1'b0; min_max = 1'b0;
        cyc(); cyc();
        chk("reset", 7'b00_0_0_0_0_0);

        // Release reset with btn_mode held: no edge may be seen
        clr = 1'b0;
        cyc(); chk("held_after_clr_1", 7'b00_0_0_0_0_0);
        cyc(); chk("held_after_clr_2", 7'b00_0_0_0_0_0);
        btn_mode = 1'b0;
        cyc(); chk("released", 7'b00_0_0_0_0_0);

        // RUN counting and carries
        tick = 1'b1; cyc(); chk("run_tick", 7'b00_0_0_0_0_1);
        tick = 1'b0; cyc(); chk("run_tick_off", 7'b00_0_0_0_0_0);
        sec_max = 1'b1;
        tick = 1'b1; cyc(); chk("run_carry_min", 7'b00_0_0_0_1_1);
        tick = 1'b0; cyc(); chk("run_carry_min_off", 7'b00_0_0_0_0_0);
        min_max = 1'b1;
        tick = 1'b1; cyc(); chk("run_carry_hr", 7'b00_0_0_1_1_1);
        tick = 1'b0; cyc(); chk("run_carry_hr_off", 7'b00_0_0_0_0_0);
        sec_max = 1'b0; min_max = 1'b0;

        // btn_inc ignored in RUN
        btn_inc = 1'b1; cyc(); chk("run_inc_ignored", 7'b00_0_0_0_0_0);
        btn_inc = 1'b0; cyc(); chk("run_inc_release", 7'b00_0_0_0_0_0);

        // Tick and mode press together: tick serviced, then SET_HR
        tick = 1'b1; btn_mode = 1'b1; cyc(); chk("tick_and_mode", 7'b01_1_0_0_0_1);
        tick = 1'b0; cyc(); chk("mode_held", 7'b01_1_0_0_0_0);
        btn_mode = 1'b0; cyc(); chk("mode_release", 7'b01_1_0_0_0_0);

        // SET_HR: inc press steps hours; ticks only toggle blink
        btn_inc = 1'b1; cyc(); chk("sethr_inc", 7'b01_1_0_1_0_0);
        cyc(); chk("sethr_inc_held", 7'b01_1_0_0_0_0);
        btn_inc = 1'b0;
        tick = 1'b1; cyc(); chk("sethr_tick_blink0", 7'b01_0_0_0_0_0);
        tick = 1'b0; cyc(); chk("sethr_tick_off", 7'b01_0_0_0_0_0);
        tick = 1'b1; cyc(); chk("sethr_tick_blink1", 7'b01_1_0_0_0_0);
        tick = 1'b0;

        // Mode and inc press together: mode wins, inc dropped
        btn_mode = 1'b1; btn_inc = 1'b1; cyc(); chk("mode_inc_same", 7'b10_1_0_0_0_0);
        btn_mode = 1'b0; btn_inc = 1'b0; cyc(); chk("setmin_idle", 7'b10_1_0_0_0_0);

        // SET_MIN: three presses at max counts, ticks interleaved
        sec_max = 1'b1; min_max = 1'b1;
        exp_blink = 1'b1;
        for (int i = 0; i < 3; i++) begin
            btn_inc = 1'b1; cyc();
            chk($sformatf("setmin_inc%0d", i), {2'd2, exp_blink, 4'b0_0_1_0});
            btn_inc = 1'b0; tick = 1'b1; cyc();
            exp_blink = ~exp_blink;
            chk($sformatf("setmin_tick%0d", i), {2'd2, exp_blink, 4'b0_0_0_0});
            tick = 1'b0;
        end
        sec_max = 1'b0; min_max = 1'b0;

        // Leave SET_MIN: one clr_sec pulse
        btn_mode = 1'b1; cyc(); chk("exit_clr_sec", 7'b00_0_1_0_0_0);
        btn_mode = 1'b0; cyc(); chk("exit_clr_sec_off", 7'b00_0_0_0_0_0);

        // Reset in SET_MIN with btn_inc held
        btn_mode = 1'b1; cyc(); chk("to_sethr", 7'b01_1_0_0_0_0);
        btn_mode = 1'b0; cyc();
        btn_mode = 1'b1; cyc(); chk("to_setmin", 7'b10_1_0_0_0_0);
        btn_mode = 1'b0; cyc();
        btn_inc = 1'b1; cyc(); chk("setmin_press", 7'b10_1_0_0_1_0);
        clr = 1'b1; #1; chk("async_clr", 7'b00_0_0_0_0_0);
        tick = 1'b1; cyc(); chk("clr_held_tick", 7'b00_0_0_0_0_0);
        tick = 1'b0; clr = 1'b0;
        cyc(); chk("post_clr_1", 7'b00_0_0_0_0_0);
        cyc(); chk("post_clr_2", 7'b00_0_0_0_0_0);
        btn_inc = 1'b0; cyc(); chk("post_clr_release", 7'b00_0_0_0_0_0);

        // Held btn_inc in SET_HR over five ticks
        btn_mode = 1'b1; cyc(); chk("rpt_enter", 7'b01_1_0_0_0_0);
        btn_mode = 1'b0; cyc();
        exp_blink = 1'b1;
        btn_inc = 1'b1; cyc(); chk("rpt_edge", 7'b01_1_0_1_0_0);
        for (int k = 1; k <= 5; k++) begin
            tick = 1'b1; cyc();
            exp_blink = ~exp_blink;
            chk($sformatf("rpt_tick%0d", k), {2'd1, exp_blink, 1'b0, (rpt_on && k > 2), 2'b00});
            tick = 1'b0; cyc();
            chk($sformatf("rpt_gap%0d", k), {2'd1, exp_blink, 4'b0_0_0_0});
        end
        btn_inc = 1'b0; cyc(); chk("rpt_release", {2'd1, exp_blink, 4'b0_0_0_0});
        tick = 1'b1; cyc();
        exp_blink = ~exp_blink;
        chk("rpt_after_release", {2'd1, exp_blink, 4'b0_0_0_0});
        tick = 1'b0; cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
